led_frame_ctrl: RTL and testbench

- Sequences the LED panel driver and arbitrates the display double buffer between software and the panel scan.
- Latches and validates the control configuration, holds the driver in reset until the configuration is stable, then enables it.
- Swaps front and back buffers only at frame boundaries, so software can write the back buffer without tearing.
- Sits between the AXI-lite control register block and the LED driver's ctrl_* inputs.

---
 rtl/led_frame_ctrl_pkg.sv | 27 ++
 rtl/led_frame_ctrl_if.sv | 51 +++++
 rtl/led_cfg_check.sv | 32 +++
 rtl/led_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_frame_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_frame_ctrl_pkg.sv
// Shared definitions for the LED frame controller and the LED driver:
// FSM state encodings, the configuration bundle and the panel limits.
package led_pkg;

    localparam int N_ROWS_MAX_DEF     = 64;
    localparam int N_COLS_MAX_DEF     = 256;
    localparam int BITDEPTH_MAX_DEF   = 8;
    localparam int LSB_BLANK_MAX_DEF  = 200;
    localparam int CTRL_REG_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_LOAD = 3'd1,
        ST_ERR  = 3'd2,
        ST_RST  = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    typedef struct packed {
        logic [CTRL_REG_WIDTH_DEF-1:0] n_rows;
        logic [CTRL_REG_WIDTH_DEF-1:0] n_cols;
        logic [CTRL_REG_WIDTH_DEF-1:0] bitdepth;
        logic [CTRL_REG_WIDTH_DEF-1:0] lsb_blank;
        logic [CTRL_REG_WIDTH_DEF-1:0] brightness;
    } led_cfg_t;

endpackage

// File: rtl/led_frame_ctrl_if.sv
// Bundle between software/driver (master) and the frame controller (slave).
interface led_frame_ctrl_if
    import led_pkg::*;
#(
    parameter int CTRL_REG_WIDTH  = CTRL_REG_WIDTH_DEF,
    parameter int FRAME_CNT_WIDTH = 16
);

    logic                       cfg_en;
    logic                       cfg_reload;
    logic [CTRL_REG_WIDTH-1:0]  cfg_n_rows;
    logic [CTRL_REG_WIDTH-1:0]  cfg_n_cols;
    logic [CTRL_REG_WIDTH-1:0]  cfg_bitdepth;
    logic [CTRL_REG_WIDTH-1:0]  cfg_lsb_blank;
    logic [CTRL_REG_WIDTH-1:0]  cfg_brightness;
    logic                       sw_swap_req;
    logic                       drv_frame_done;

    logic                       drv_en;
    logic                       drv_rst;
    logic [CTRL_REG_WIDTH-1:0]  drv_n_rows;
    logic [CTRL_REG_WIDTH-1:0]  drv_n_cols;
    logic [CTRL_REG_WIDTH-1:0]  drv_bitdepth;
    logic [CTRL_REG_WIDTH-1:0]  drv_lsb_blank;
    logic [CTRL_REG_WIDTH-1:0]  drv_brightness;
    logic                       disp_buffer;
    logic                       sw_buffer;
    logic                       swap_pending;
    logic                       swap_ack;
    logic                       sw_overrun;
    logic                       irq_frame;
    logic [FRAME_CNT_WIDTH-1:0] frame_count;
    logic                       cfg_err;

    modport master (
        output cfg_en, cfg_reload, cfg_n_rows, cfg_n_cols, cfg_bitdepth,
               cfg_lsb_blank, cfg_brightness, sw_swap_req, drv_frame_done,
        input  drv_en, drv_rst, drv_n_rows, drv_n_cols, drv_bitdepth,
               drv_lsb_blank, drv_brightness, disp_buffer, sw_buffer,
               swap_pending, swap_ack, sw_overrun, irq_frame, frame_count, cfg_err
    );

    modport slave (
        input  cfg_en, cfg_reload, cfg_n_rows, cfg_n_cols, cfg_bitdepth,
               cfg_lsb_blank, cfg_brightness, sw_swap_req, drv_frame_done,
        output drv_en, drv_rst, drv_n_rows, drv_n_cols, drv_bitdepth,
               drv_lsb_blank, drv_brightness, disp_buffer, sw_buffer,
               swap_pending, swap_ack, sw_overrun, irq_frame, frame_count, cfg_err
    );

endinterface

// File: rtl/led_cfg_check.sv
// Combinational validity check of a configuration against the panel limits.
module led_cfg_check
    import led_pkg::*;
#(
    parameter int N_ROWS_MAX    = N_ROWS_MAX_DEF,
    parameter int N_COLS_MAX    = N_COLS_MAX_DEF,
    parameter int BITDEPTH_MAX  = BITDEPTH_MAX_DEF,
    parameter int LSB_BLANK_MAX = LSB_BLANK_MAX_DEF
) (
    input  led_cfg_t cfg_i,
    output logic     valid_o
);

    localparam int W = CTRL_REG_WIDTH_DEF;
    localparam logic [W-1:0] ROWS_MAX  = W'(N_ROWS_MAX);
    localparam logic [W-1:0] COLS_MAX  = W'(N_COLS_MAX);
    localparam logic [W-1:0] DEPTH_MAX = W'(BITDEPTH_MAX);
    localparam logic [W-1:0] BLANK_MAX = W'(LSB_BLANK_MAX);

    logic rows_ok, cols_ok, depth_ok, blank_ok, bright_ok;

    // Every compare is unsigned at full register width so huge values never alias small ones.
    always_comb begin
        rows_ok   = !cfg_i.n_rows[0] && (cfg_i.n_rows >= W'(2)) && (cfg_i.n_rows <= ROWS_MAX);
        cols_ok   = (cfg_i.n_cols >= W'(1)) && (cfg_i.n_cols <= COLS_MAX);
        depth_ok  = (cfg_i.bitdepth >= W'(1)) && (cfg_i.bitdepth <= DEPTH_MAX);
        blank_ok  = (cfg_i.lsb_blank >= W'(1)) && (cfg_i.lsb_blank <= BLANK_MAX);
        bright_ok = cfg_i.brightness < cfg_i.lsb_blank;
        valid_o   = rows_ok && cols_ok && depth_ok && blank_ok && bright_ok;
    end

endmodule

// File: rtl/led_frame_ctrl.sv
// LED panel driver sequencer and display double-buffer arbiter.
module led_frame_ctrl
    import led_pkg::*;
#(
    parameter int N_ROWS_MAX      = N_ROWS_MAX_DEF,
    parameter int N_COLS_MAX      = N_COLS_MAX_DEF,
    parameter int BITDEPTH_MAX    = BITDEPTH_MAX_DEF,
    parameter int LSB_BLANK_MAX   = LSB_BLANK_MAX_DEF,
    parameter int RST_CYCLES      = 4,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             ctrl_rst,
    led_frame_ctrl_if.slave  bus
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t                     state_q, state_d;
    logic [RCW-1:0]             rst_cnt_q, rst_cnt_d;
    logic                       reload_q, reload_d;
    logic                       swap_pend_q, swap_pend_d;
    logic                       disp_q, disp_d;
    logic                       sw_buf_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    led_cfg_t                   drv_cfg_q;
    logic                       drv_en_q, drv_rst_q, cfg_err_q;
    logic                       swap_ack_q, overrun_q, irq_q;

    led_cfg_t cfg_in;
    logic     cfg_ok;
    logic     run_active, frame_evt, swap_apply, overrun;

    assign cfg_in = '{n_rows:     bus.cfg_n_rows,
                      n_cols:     bus.cfg_n_cols,
                      bitdepth:   bus.cfg_bitdepth,
                      lsb_blank:  bus.cfg_lsb_blank,
                      brightness: bus.cfg_brightness};

    led_cfg_check #(
        .N_ROWS_MAX    (N_ROWS_MAX),
        .N_COLS_MAX    (N_COLS_MAX),
        .BITDEPTH_MAX  (BITDEPTH_MAX),
        .LSB_BLANK_MAX (LSB_BLANK_MAX)
    ) u_cfg_check (
        .cfg_i   (cfg_in),
        .valid_o (cfg_ok)
    );

    // Dropping cfg_en wins over every other transition.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        reload_d   = reload_q;
        run_active = 1'b0;
        if (!bus.cfg_en && (state_q != ST_OFF)) begin
            state_d  = ST_OFF;
            reload_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF:  if (bus.cfg_en) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (!cfg_ok) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d   = ST_RST;
                        rst_cnt_d = RCW'(RST_CYCLES - 1);
                    end
                end
                ST_ERR:  state_d = ST_ERR;
                ST_RST: begin
                    if (rst_cnt_q == '0) state_d = ST_RUN;
                    else                 rst_cnt_d = rst_cnt_q - RCW'(1);
                end
                ST_RUN: begin
                    run_active = 1'b1;
                    if (reload_q && bus.drv_frame_done) begin
                        state_d  = ST_LOAD;
                        reload_d = 1'b0;
                    end else if (bus.cfg_reload) begin
                        reload_d = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // A pending swap is consumed by frame_done; a request only queues when nothing is pending.
    always_comb begin
        frame_evt   = run_active && bus.drv_frame_done;
        swap_apply  = frame_evt && swap_pend_q;
        overrun     = run_active && bus.sw_swap_req && swap_pend_q;
        swap_pend_d = swap_pend_q;
        if (run_active) begin
            swap_pend_d = swap_pend_q ? !bus.drv_frame_done : bus.sw_swap_req;
        end else if (state_d == ST_OFF) begin
            swap_pend_d = 1'b0;
        end
        disp_d      = disp_q ^ swap_apply;
        frame_cnt_d = frame_cnt_q + (frame_evt ? FRAME_CNT_WIDTH'(1) : FRAME_CNT_WIDTH'(0));
    end

    always_ff @(posedge clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_q     <= ST_OFF;
            rst_cnt_q   <= '0;
            reload_q    <= 1'b0;
            swap_pend_q <= 1'b0;
            disp_q      <= 1'b0;
            sw_buf_q    <= 1'b1;
            frame_cnt_q <= '0;
            drv_cfg_q   <= '0;
            drv_en_q    <= 1'b0;
            drv_rst_q   <= 1'b1;
            cfg_err_q   <= 1'b0;
            swap_ack_q  <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            reload_q    <= reload_d;
            swap_pend_q <= swap_pend_d;
            disp_q      <= disp_d;
            sw_buf_q    <= ~disp_d;
            frame_cnt_q <= frame_cnt_d;
            if (state_q == ST_LOAD) drv_cfg_q <= cfg_in;
            drv_en_q    <= (state_d == ST_RUN);
            drv_rst_q   <= (state_d != ST_RUN);
            cfg_err_q   <= (state_d == ST_ERR);
            swap_ack_q  <= swap_apply;
            overrun_q   <= overrun;
            irq_q       <= frame_evt;
        end
    end

    assign bus.drv_en         = drv_en_q;
    assign bus.drv_rst        = drv_rst_q;
    assign bus.drv_n_rows     = drv_cfg_q.n_rows;
    assign bus.drv_n_cols     = drv_cfg_q.n_cols;
    assign bus.drv_bitdepth   = drv_cfg_q.bitdepth;
    assign bus.drv_lsb_blank  = drv_cfg_q.lsb_blank;
    assign bus.drv_brightness = drv_cfg_q.brightness;
    assign bus.disp_buffer    = disp_q;
    assign bus.sw_buffer      = sw_buf_q;
    assign bus.swap_pending   = swap_pend_q;
    assign bus.swap_ack       = swap_ack_q;
    assign bus.sw_overrun     = overrun_q;
    assign bus.irq_frame      = irq_q;
    assign bus.frame_count    = frame_cnt_q;
    assign bus.cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed and randomized bench for led_frame_ctrl against a rule-level reference model.
module tb_led_frame_ctrl;
    import led_pkg::*;

    localparam int FCW  = 8;
    localparam int RSTC = 4;

    logic clk = 1'b0;
    logic ctrl_rst;
    int   checks   = 0;
    int   failures = 0;

    bit mDisp;
    bit mPend;
    int mCount;

    led_frame_ctrl_if #(.CTRL_REG_WIDTH(32), .FRAME_CNT_WIDTH(FCW)) bus ();

    led_frame_ctrl #(
        .N_ROWS_MAX      (64),
        .N_COLS_MAX      (256),
        .BITDEPTH_MAX    (8),
        .LSB_BLANK_MAX   (200),
        .RST_CYCLES      (RSTC),
        .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clk      (clk),
        .ctrl_rst (ctrl_rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCfg(input logic [31:0] r, input logic [31:0] c, input logic [31:0] b,
                          input logic [31:0] l, input logic [31:0] br);
        bus.cfg_n_rows     = r;
        bus.cfg_n_cols     = c;
        bus.cfg_bitdepth   = b;
        bus.cfg_lsb_blank  = l;
        bus.cfg_brightness = br;
    endtask

    function automatic bit cfgValid(input int unsigned r, input int unsigned c, input int unsigned b,
                                    input int unsigned l, input int unsigned br);
        return (r % 2 == 0) && (r >= 2) && (r <= 64) && (c >= 1) && (c <= 256) &&
               (b >= 1) && (b <= 8) && (l >= 1) && (l <= 200) && (br < l);
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_drv_en"},   32'(bus.drv_en), 0);
        checkOutput({tag, "_drv_rst"},  32'(bus.drv_rst), 1);
        checkOutput({tag, "_n_rows"},   bus.drv_n_rows, 0);
        checkOutput({tag, "_n_cols"},   bus.drv_n_cols, 0);
        checkOutput({tag, "_bright"},   bus.drv_brightness, 0);
        checkOutput({tag, "_disp"},     32'(bus.disp_buffer), 0);
        checkOutput({tag, "_swbuf"},    32'(bus.sw_buffer), 1);
        checkOutput({tag, "_pending"},  32'(bus.swap_pending), 0);
        checkOutput({tag, "_ack"},      32'(bus.swap_ack), 0);
        checkOutput({tag, "_overrun"},  32'(bus.sw_overrun), 0);
        checkOutput({tag, "_irq"},      32'(bus.irq_frame), 0);
        checkOutput({tag, "_count"},    32'(bus.frame_count), 0);
        checkOutput({tag, "_cfg_err"},  32'(bus.cfg_err), 0);
    endtask

    // One RUN cycle: drive the pulses, then compare against the rule model.
    task automatic applyStimulus(input bit req, input bit fd);
        bit expAck, expOvr;
        bus.sw_swap_req    = req;
        bus.drv_frame_done = fd;
        tick();
        bus.sw_swap_req    = 1'b0;
        bus.drv_frame_done = 1'b0;
        expAck = fd && mPend;
        expOvr = req && mPend;
        if (fd)     mCount = (mCount + 1) % (1 << FCW);
        if (expAck) mDisp = !mDisp;
        if (mPend)  mPend = !fd;
        else        mPend = req;
        checkOutput("run_disp",    32'(bus.disp_buffer), 32'(mDisp));
        checkOutput("run_swbuf",   32'(bus.sw_buffer), 32'(!mDisp));
        checkOutput("run_pending", 32'(bus.swap_pending), 32'(mPend));
        checkOutput("run_ack",     32'(bus.swap_ack), 32'(expAck));
        checkOutput("run_overrun", 32'(bus.sw_overrun), 32'(expOvr));
        checkOutput("run_irq",     32'(bus.irq_frame), 32'(fd));
        checkOutput("run_count",   32'(bus.frame_count), 32'(mCount));
    endtask

    initial begin
        logic [31:0] r, c, b, l, br;
        bit          v;
        time         tRst;

        ctrl_rst           = 1'b1;
        bus.cfg_en         = 1'b0;
        bus.cfg_reload     = 1'b0;
        bus.sw_swap_req    = 1'b0;
        bus.drv_frame_done = 1'b0;
        setCfg(64, 256, 8, 200, 0);
        mDisp  = 1'b0;
        mPend  = 1'b0;
        mCount = 0;

        #12;
        checkResetValues("reset");
        ctrl_rst = 1'b0;
        tick();

        $display("[TB] enable with valid config");
        bus.cfg_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("en_c5_drv_en",  32'(bus.drv_en), 0);
        checkOutput("en_c5_drv_rst", 32'(bus.drv_rst), 1);
        tick();
        checkOutput("en_c6_drv_en",  32'(bus.drv_en), 1);
        checkOutput("en_c6_drv_rst", 32'(bus.drv_rst), 0);
        checkOutput("en_n_rows",     bus.drv_n_rows, 64);
        checkOutput("en_n_cols",     bus.drv_n_cols, 256);
        checkOutput("en_bitdepth",   bus.drv_bitdepth, 8);
        checkOutput("en_lsb_blank",  bus.drv_lsb_blank, 200);
        checkOutput("en_bright",     bus.drv_brightness, 0);
        checkOutput("en_cfg_err",    32'(bus.cfg_err), 0);

        $display("[TB] basic swap");
        applyStimulus(1, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0);
        applyStimulus(0, 1);
        checkOutput("swap1_disp",  32'(bus.disp_buffer), 1);
        checkOutput("swap1_swbuf", 32'(bus.sw_buffer), 0);
        checkOutput("swap1_count", 32'(bus.frame_count), 1);
        applyStimulus(0, 0);

        $display("[TB] simultaneous events");
        applyStimulus(1, 1);
        checkOutput("simul0_disp",    32'(bus.disp_buffer), 1);
        checkOutput("simul0_pending", 32'(bus.swap_pending), 1);
        applyStimulus(0, 1);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 1);
        applyStimulus(1, 0);
        applyStimulus(1, 1);
        checkOutput("simul1_pending", 32'(bus.swap_pending), 0);
        checkOutput("simul1_overrun", 32'(bus.sw_overrun), 1);

        $display("[TB] random swap traffic");
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            checkOutput("rand_drv_en", 32'(bus.drv_en), 1);
        end

        $display("[TB] config hold and reload");
        if (mPend) applyStimulus(0, 1);
        bus.cfg_n_cols = 128;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);
        checkOutput("hold_n_cols", bus.drv_n_cols, 256);
        bus.cfg_reload = 1'b1;
        applyStimulus(0, 0);
        bus.cfg_reload = 1'b0;
        checkOutput("reload_still_run", 32'(bus.drv_en), 1);
        applyStimulus(0, 1);
        checkOutput("reload_load_en",  32'(bus.drv_en), 0);
        checkOutput("reload_load_rst", 32'(bus.drv_rst), 1);
        tick();
        checkOutput("reload_n_cols", bus.drv_n_cols, 128);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("reload_rst_en", 32'(bus.drv_en), 0);
        tick();
        checkOutput("reload_run_en",  32'(bus.drv_en), 1);
        checkOutput("reload_run_rst", 32'(bus.drv_rst), 0);

        $display("[TB] invalid config");
        bus.cfg_en = 1'b0;
        tick();
        mPend = 1'b0;
        checkOutput("off_drv_en",  32'(bus.drv_en), 0);
        checkOutput("off_drv_rst", 32'(bus.drv_rst), 1);
        checkOutput("off_pending", 32'(bus.swap_pending), 0);
        checkOutput("off_disp",    32'(bus.disp_buffer), 32'(mDisp));
        checkOutput("off_count",   32'(bus.frame_count), 32'(mCount));
        bus.cfg_n_rows = 63;
        bus.cfg_en     = 1'b1;
        tick();
        checkOutput("inv_c1_cfg_err", 32'(bus.cfg_err), 0);
        tick();
        checkOutput("inv_c2_cfg_err", 32'(bus.cfg_err), 1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("inv_drv_en",  32'(bus.drv_en), 0);
        checkOutput("inv_drv_rst", 32'(bus.drv_rst), 1);
        bus.cfg_en = 1'b0;
        tick();
        checkOutput("inv_exit_cfg_err", 32'(bus.cfg_err), 0);
        checkOutput("inv_exit_drv_en",  32'(bus.drv_en), 0);

        $display("[TB] random configs");
        for (int i = 0; i < 16; i++) begin
            r  = 32'(2 * $urandom_range(1, 32));
            c  = 32'($urandom_range(1, 256));
            b  = 32'($urandom_range(1, 8));
            l  = 32'($urandom_range(1, 200));
            br = 32'($urandom_range(0, int'(l) - 1));
            case ($urandom_range(0, 11))
                0: r  = r - 1;
                1: r  = 66;
                2: c  = 0;
                3: c  = 257;
                4: b  = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd9;
                5: l  = 201;
                6: br = l;
                7: r  = 32'hFFFF_FFFE;
                default: ;
            endcase
            v = cfgValid(r, c, b, l, br);
            setCfg(r, c, b, l, br);
            bus.cfg_en = 1'b1;
            tick();
            tick();
            checkOutput("rcfg_cfg_err", 32'(bus.cfg_err), 32'(!v));
            checkOutput("rcfg_n_rows",  bus.drv_n_rows, r);
            checkOutput("rcfg_bright",  bus.drv_brightness, br);
            for (int k = 0; k < 4; k++) tick();
            checkOutput("rcfg_drv_en",  32'(bus.drv_en), 32'(v));
            bus.cfg_en = 1'b0;
            tick();
            checkOutput("rcfg_off_en",  32'(bus.drv_en), 0);
            checkOutput("rcfg_off_err", 32'(bus.cfg_err), 0);
        end

        $display("[TB] async reset mid-run");
        setCfg(64, 256, 8, 200, 0);
        bus.cfg_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("ar_run_en", 32'(bus.drv_en), 1);
        applyStimulus(1, 0);
        checkOutput("ar_pending", 32'(bus.swap_pending), 1);
        #2;
        tRst = $time;
        ctrl_rst = 1'b1;
        #1;
        checkResetValues("async");
        checkOutput("ar_no_edge", 32'(($time - tRst) < 5), 1);
        #2;
        ctrl_rst = 1'b0;
        mDisp  = 1'b0;
        mPend  = 1'b0;
        mCount = 0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("ar_rerun_en", 32'(bus.drv_en), 1);

        $display("[TB] frame count wrap");
        for (int i = 0; i < 255; i++) applyStimulus($urandom_range(0, 1) == 1, 1);
        checkOutput("wrap_255", 32'(bus.frame_count), 255);
        applyStimulus(0, 1);
        checkOutput("wrap_0", 32'(bus.frame_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
